// File: rtl/arp_pkg.sv
// arp_pkg: ARP-over-Ethernet field values and byte offsets, shared by the ARP
// receive (learn) path and the ARP transmitter.
package arp_pkg;

    localparam logic [15:0] ETYPE_ARP  = 16'h0806;
    localparam logic [15:0] HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  HLEN_ETH   = 8'h06;
    localparam logic [7:0]  PLEN_IPV4  = 8'h04;
    localparam logic [15:0] OP_REQUEST = 16'h0001;
    localparam logic [15:0] OP_REPLY   = 16'h0002;

    // Byte offsets from the first byte of the Ethernet header
    localparam logic [5:0] OFF_ETYPE = 6'd12;
    localparam logic [5:0] OFF_HTYPE = 6'd14;
    localparam logic [5:0] OFF_PTYPE = 6'd16;
    localparam logic [5:0] OFF_HLEN  = 6'd18;
    localparam logic [5:0] OFF_PLEN  = 6'd19;
    localparam logic [5:0] OFF_OPER  = 6'd20;
    localparam logic [5:0] OFF_SHA   = 6'd22;
    localparam logic [5:0] OFF_SPA   = 6'd28;
    localparam logic [5:0] OFF_THA   = 6'd32;
    localparam logic [5:0] OFF_TPA   = 6'd38;
    localparam logic [5:0] OFF_LAST  = 6'd41;
    localparam logic [5:0] IDX_MAX   = 6'd63;

    typedef enum logic [1:0] {ST_RX, ST_SKIP, ST_COMMIT} state_e;

    function automatic logic hdr_byte_ok(input logic [5:0] idx, input logic [7:0] b);
        return idx == OFF_ETYPE         ? b == ETYPE_ARP[15:8]  :
               idx == OFF_ETYPE + 6'd1  ? b == ETYPE_ARP[7:0]   :
               idx == OFF_HTYPE         ? b == HTYPE_ETH[15:8]  :
               idx == OFF_HTYPE + 6'd1  ? b == HTYPE_ETH[7:0]   :
               idx == OFF_PTYPE         ? b == PTYPE_IPV4[15:8] :
               idx == OFF_PTYPE + 6'd1  ? b == PTYPE_IPV4[7:0]  :
               idx == OFF_HLEN          ? b == HLEN_ETH         :
               idx == OFF_PLEN          ? b == PLEN_IPV4        :
               idx == OFF_OPER          ? b == OP_REQUEST[15:8] :
               idx == OFF_OPER + 6'd1   ? (b == OP_REQUEST[7:0] || b == OP_REPLY[7:0]) :
               1'b1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, async active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (inc_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/arp_learn.sv
// arp_learn: parses received ARP frames byte by byte and emits a one-cycle
// cache write of the sender IP/MAC, plus a pulse when a request targets us.
module arp_learn
    import arp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_last,
    input  logic [31:0]      local_ip,
    output logic [31:0]      ip_o,
    output logic [47:0]      mac_o,
    output logic             wea,
    output logic             req_hit,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    state_e      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [47:0] sha_q, sha_d;
    logic [31:0] spa_q, spa_d;
    logic [31:0] tpa_q, tpa_d;
    logic        op_req_q, op_req_d;
    logic        pass, frame_end, long_enough, learn, hit;

    // Fields are evaluated on their _d values so a frame ending on the last TPA byte sees it
    always_comb begin
        sha_d       = (rx_valid && idx_q >= OFF_SHA && idx_q < OFF_SPA) ? {sha_q[39:0], rx_data} : sha_q;
        spa_d       = (rx_valid && idx_q >= OFF_SPA && idx_q < OFF_THA) ? {spa_q[23:0], rx_data} : spa_q;
        tpa_d       = (rx_valid && idx_q >= OFF_TPA && idx_q <= OFF_LAST) ? {tpa_q[23:0], rx_data} : tpa_q;
        op_req_d    = (rx_valid && idx_q == OFF_OPER + 6'd1) ? rx_data == OP_REQUEST[7:0] : op_req_q;
        pass        = state_q != ST_SKIP && hdr_byte_ok(idx_q, rx_data);
        frame_end   = rx_valid && rx_last;
        long_enough = idx_q >= OFF_LAST;
        hit         = frame_end && pass && long_enough && op_req_d && tpa_d == local_ip;
        learn       = frame_end && pass && long_enough && (!op_req_d || tpa_d == local_ip)
                      && spa_d != '0 && !sha_d[40];
        idx_d       = !rx_valid ? idx_q : rx_last ? 6'd0 : idx_q == IDX_MAX ? idx_q : idx_q + 6'd1;
        state_d     = !rx_valid ? (state_q == ST_COMMIT ? ST_RX : state_q) :
                      learn ? ST_COMMIT : (frame_end || pass) ? ST_RX : ST_SKIP;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RX;
            idx_q    <= '0;
            sha_q    <= '0;
            spa_q    <= '0;
            tpa_q    <= '0;
            op_req_q <= 1'b0;
            wea      <= 1'b0;
            req_hit  <= 1'b0;
            ip_o     <= '0;
            mac_o    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sha_q    <= sha_d;
            spa_q    <= spa_d;
            tpa_q    <= tpa_d;
            op_req_q <= op_req_d;
            wea      <= learn;
            req_hit  <= hit;
            if (learn) begin
                ip_o  <= spa_d;
                mac_o <= sha_d;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_ok_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc_i (learn),
        .cnt_o (ok_cnt)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc_i (frame_end && !learn),
        .cnt_o (drop_cnt)
    );

endmodule
